// File: rtl/bcd_conv_scheduler.sv
// Round-robin shared sequential double-dabble binary-to-BCD converter.
// Optional macro BCD_LEAD_ZERO_BLANK_EN replaces leading zero digits with 4'hF.
module bcd_conv_scheduler #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned BIN_W      = 16,
  parameter int unsigned BCD_DIGITS = 5,
  localparam int unsigned ID_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*BIN_W-1:0] bin_in,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic [4*BCD_DIGITS-1:0]  bcd_out,
  output logic [ID_W-1:0]          bcd_id,
  output logic                     bcd_valid
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = (BIN_W > 2) ? $clog2(BIN_W) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_next;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   cur_id;
  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] req_hi;
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_id;
  logic [BCD_W-1:0]  digits_c;
  logic [BCD_W-1:0]  result_c;

  // Round-robin pick: lowest request above the pointer, else lowest overall.
  always_comb begin
    hi_mask = ~((NUM_REQ'(2) << ptr) - NUM_REQ'(1));
    req_hi  = req & hi_mask;
    gnt_vld = |req;
    gnt_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) gnt_id = ID_W'(i);
    end
    if (|req_hi) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_hi[i]) gnt_id = ID_W'(i);
      end
    end
  end

  // One double-dabble iteration: add 3 to every digit >= 5, then shift left.
  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (sr[BIN_W + 4*k +: 4] >= 4'd5)
        sr_adj[BIN_W + 4*k +: 4] = sr[BIN_W + 4*k +: 4] + 4'd3;
    end
    sr_next = {sr_adj[SR_W-2:0], 1'b0};
  end

  assign digits_c = sr_next[SR_W-1 -: BCD_W];

`ifdef BCD_LEAD_ZERO_BLANK_EN
  // Digit 0 always shows, so zero renders as a single 0.
  function automatic logic [BCD_W-1:0] blank_lead(input logic [BCD_W-1:0] d);
    logic lead;
    blank_lead = d;
    lead       = 1'b1;
    for (int k = BCD_DIGITS - 1; k >= 1; k--) begin
      if (lead && (d[4*k +: 4] == 4'd0))
        blank_lead[4*k +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
  endfunction

  assign result_c = blank_lead(digits_c);
`else
  assign result_c = digits_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= '0;
      busy      <= 1'b0;
      bcd_out   <= '0;
      bcd_id    <= '0;
      bcd_valid <= 1'b0;
      cnt       <= '0;
      ptr       <= ID_W'(NUM_REQ - 1);
      cur_id    <= '0;
      sr        <= '0;
    end else begin
      ack       <= '0;
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            ack    <= NUM_REQ'(1) << gnt_id;
            sr     <= {BCD_W'(0), bin_in[gnt_id*BIN_W +: BIN_W]};
            cur_id <= gnt_id;
            ptr    <= gnt_id;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          sr  <= sr_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            bcd_out   <= result_c;
            bcd_id    <= cur_id;
            bcd_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bcd_conv_scheduler.md
Name: bcd_conv_scheduler

Overview:
- Shares one sequential double-dabble binary-to-BCD engine between NUM_REQ requesters, e.g. the SHT30 temperature and humidity result paths.
- Arbitration is round-robin.
- Each conversion is one add-3/shift iteration per clock, so no wide combinational loop is needed.
- Sits between the sensor result registers and the display/segment driver; returns the BCD result tagged with the requester ID.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BIN_W, 16, binary input width per requester.
- BCD_DIGITS, 5, output digits; must satisfy 10^BCD_DIGITS > 2^BIN_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req  in  NUM_REQ  per-requester conversion request, level
- bin_in  in  NUM_REQ*BIN_W  packed operands; requester i at [i*BIN_W +: BIN_W]
- ack  out  NUM_REQ  one-hot, one-cycle grant pulse; operand captured on this edge
- busy  out  1  engine occupied
- bcd_out  out  4*BCD_DIGITS  converted result; digit k at [4k+3:4k], digit 0 = units
- bcd_id  out  ID_W  index of the requester owning bcd_out; ID_W = max(1, clog2(NUM_REQ))
- bcd_valid  out  1  one-cycle result strobe

Behaviour:
- Clocking and reset:
  - Single clock, synchronous active-high reset. All state updates on the rising edge of clk.
  - Reset values: ack=0, busy=0, bcd_out=0, bcd_id=0, bcd_valid=0, state=IDLE, iteration count=0, round-robin pointer=NUM_REQ-1 (so requester 0 has top priority after reset).
- States: IDLE, CONV.
- IDLE:
  - If any req bit is set, grant the first set bit scanning upward from pointer+1, modulo NUM_REQ.
  - On that edge: ack[g]<=1 for exactly one cycle; shift register <= {zeros, bin_in[g]}; id <= g; pointer <= g; count <= 0; busy <= 1; state <= CONV.
  - If req == 0, remain in IDLE.
- CONV, one iteration per clock:
  - For each BCD digit >= 5, add 3 (4-bit, no carry into the next digit).
  - Then shift the whole register left by 1.
  - count increments each iteration.
- Final iteration (count == BIN_W-1), on that same edge:
  - bcd_out <= final digit field; bcd_id <= id; bcd_valid <= 1.
  - busy <= 0; state <= IDLE.
- Latency: bcd_valid rises exactly BIN_W clocks after the edge that raised ack (16 with defaults).
- Throughput: IDLE can grant on the cycle bcd_valid is high, giving one conversion per BIN_W+1 clocks back-to-back.
- bcd_out and bcd_id hold their value until the next bcd_valid; bcd_valid is never high for two consecutive cycles.
- Requester protocol:
  - Requester holds req and a stable bin_in until it sees ack.
  - req deasserted before grant means no conversion.
  - req held after ack is a new request.
  - bin_in changes after ack do not affect the conversion in flight.
  - req is ignored in CONV (no queueing beyond the level req).
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,NUM_REQ-1,0,...
- Boundaries:
  - Input 0 gives all-zero digits.
  - Input 2^BIN_W-1 converts exactly (digit-count constraint guarantees no overflow).
  - A single active requester is re-granted every BIN_W+1 clocks.
- Reset mid-conversion: the conversion is aborted with no bcd_valid, and all registers return to reset values on that edge.

Optional Feature:
- Macro: BCD_LEAD_ZERO_BLANK_EN.
- Defined:
  - At result load, every leading zero digit above the most significant nonzero digit is replaced with 4'hF (blank code for the segment decoder).
  - Digit 0 is never blanked, so input 0 gives ...FFF0.
  - Blanking is applied to the value registered into bcd_out; latency is unchanged.
- Undefined: bcd_out is plain BCD with zero digits kept.

Test Plan:
- req=2'b01, bin_in[15:0]=16'd1234 -> ack=2'b01 for one cycle, then 16 clocks later bcd_valid=1, bcd_out=20'h01234, bcd_id=0. With BCD_LEAD_ZERO_BLANK_EN: bcd_out=20'hF1234.
- Boundary values on requester 1:
  - 16'd65535 -> 20'h65535, bcd_id=1.
  - 16'd0 -> 20'h00000; with the macro, 20'hFFFF0.
  - 16'd9 -> 20'h00009.
- req=2'b11 held continuously (op0=100, op1=200), starting from reset:
  - ack sequence 01,10,01,...; results 20'h00100 id0, 20'h00200 id1, alternating.
  - Grant spacing 17 clocks; no back-to-back bcd_valid.
- req0 granted with 16'd4321, then bin_in[15:0] changed to 16'd9999 the cycle after ack -> result still 20'h04321.
- rst asserted for one cycle at iteration 8 of a conversion -> no bcd_valid; busy=0, bcd_out=0 next cycle. The next req0 is granted first and converts correctly.
- Single requester req=2'b10 held 3 conversions (op=16'd42) -> three bcd_valid pulses 17 clocks apart, each 20'h00042, id1.
